// File: rtl/itch_msg_sequencer_if.sv
// itch_msg_sequencer_if: byte stream, decoder handshake and status bundle of the ITCH sequencer
// Ports: master modport drives byte_in/valid_in/dec_valid_any and observes everything else;
//        slave modport is the sequencer side.
interface itch_msg_sequencer_if;
    logic [7:0]  byte_in;
    logic        valid_in;
    logic        dec_valid_any;
    logic        dec_enable;
    logic        msg_start;
    logic [7:0]  msg_type;
    logic [5:0]  byte_index;
    logic        msg_end;
    logic        unknown_type;
    logic        trunc_error;
    logic        dec_mismatch;
    logic [15:0] msg_count;
    logic [15:0] err_count;
    modport master (
        output byte_in, valid_in, dec_valid_any,
        input  dec_enable, msg_start, msg_type, byte_index, msg_end,
        input  unknown_type, trunc_error, dec_mismatch, msg_count, err_count
    );
    modport slave (
        input  byte_in, valid_in, dec_valid_any,
        output dec_enable, msg_start, msg_type, byte_index, msg_end,
        output unknown_type, trunc_error, dec_mismatch, msg_count, err_count
    );
endinterface

// File: rtl/itch_msg_sequencer.sv
// itch_msg_sequencer: frames an ITCH byte stream into messages and enables the field decoders
// Ports: clk, rst_n (asynchronous, active-low); bus (slave side of itch_msg_sequencer_if):
//   in : byte_in, valid_in, dec_valid_any
//   out: dec_enable, msg_start, msg_type, byte_index (same cycle as the byte),
//        msg_end, trunc_error, dec_mismatch (one cycle later), unknown_type (same cycle),
//        msg_count, err_count (saturating statistics)
// Build option: define ITCH_SEQ_STATS_EN to implement msg_count/err_count; otherwise both read 0.
module itch_msg_sequencer #(
    parameter int MAX_LEN = 44
) (
    input logic clk,
    input logic rst_n,
    itch_msg_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, IN_MSG, DISCARD} state_t;
    state_t state, state_nx;
    logic [5:0] idx, idx_nx, len, tbl_len;
    logic [7:0] type_q;
    logic end_q, trunc_q, mism_q, known, start, unknown, in_byte, last;

    assign tbl_len = bus.byte_in == 8'h41 ? 6'd36 :
                     bus.byte_in == 8'h58 ? 6'd23 :
                     bus.byte_in == 8'h44 ? 6'd9  :
                     bus.byte_in == 8'h55 ? 6'd27 :
                     bus.byte_in == 8'h45 ? 6'd31 :
                     bus.byte_in == 8'h50 ? 6'd44 : 6'd0;
    // a type longer than MAX_LEN is treated as unknown, which keeps byte_index below MAX_LEN
    assign known = tbl_len != 6'd0 && int'(tbl_len) <= MAX_LEN;
    // same-cycle strobes are gated by rst_n so every output reads 0 while reset is held
    assign start = rst_n && bus.valid_in && state == IDLE && known;
    assign unknown = rst_n && bus.valid_in && state == IDLE && !known;
    assign in_byte = rst_n && bus.valid_in && state == IN_MSG;
    assign last = in_byte && idx == len - 6'd1;

    assign bus.dec_enable = start || in_byte;
    assign bus.msg_start = start;
    assign bus.msg_type = start ? bus.byte_in : type_q;
    assign bus.byte_index = in_byte ? idx : 6'd0;
    assign bus.unknown_type = unknown;
    assign bus.msg_end = end_q;
    assign bus.trunc_error = trunc_q;
    assign bus.dec_mismatch = mism_q;

    always_comb begin
        state_nx = state;
        idx_nx = start ? 6'd1 : (in_byte && !last) ? idx + 6'd1 : 6'd0;
        case (state)
            IDLE:    state_nx = !bus.valid_in ? IDLE : known ? IN_MSG : DISCARD;
            IN_MSG:  state_nx = (!bus.valid_in || last) ? IDLE : IN_MSG;
            default: state_nx = bus.valid_in ? DISCARD : IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx <= 6'd0;
            len <= 6'd0;
            type_q <= 8'd0;
            end_q <= 1'b0;
            trunc_q <= 1'b0;
            mism_q <= 1'b0;
        end else begin
            state <= state_nx;
            idx <= idx_nx;
            len <= start ? tbl_len : len;
            type_q <= start ? bus.byte_in : type_q;
            end_q <= last;
            trunc_q <= state == IN_MSG && !bus.valid_in;
            // decoders must report exactly in the msg_end cycle and never elsewhere
            mism_q <= end_q ? !bus.dec_valid_any : bus.dec_valid_any;
        end
    end

`ifdef ITCH_SEQ_STATS_EN
    logic [15:0] msg_cnt, err_cnt;
    logic err_inc;
    // coincident error events count once
    assign err_inc = unknown || trunc_q || mism_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_cnt <= 16'd0;
            err_cnt <= 16'd0;
        end else begin
            msg_cnt <= (end_q && msg_cnt != 16'hFFFF) ? msg_cnt + 16'd1 : msg_cnt;
            err_cnt <= (err_inc && err_cnt != 16'hFFFF) ? err_cnt + 16'd1 : err_cnt;
        end
    end
    assign bus.msg_count = msg_cnt;
    assign bus.err_count = err_cnt;
`else
    assign bus.msg_count = 16'd0;
    assign bus.err_count = 16'd0;
`endif
endmodule

// File: tb/tb_itch_msg_sequencer.sv
// tb_itch_msg_sequencer: scoreboard bench for itch_msg_sequencer
module tb_itch_msg_sequencer;
    localparam int K_START = 0, K_END = 1, K_UNK = 2, K_TRUNC = 3, K_MISM = 4, K_LVL = 5;
`ifdef ITCH_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    typedef struct {int kind; int cyc; int val;} ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    itch_msg_sequencer_if bus();
    itch_msg_sequencer #(.MAX_LEN(44)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int cyc = 0;
    int now = 0;
    int checks = 0;
    int errors = 0;
    int exp_msgs = 0;
    int exp_errs = 0;
    bit pend_dv = 1'b0;

    // monitor: every output event observed, tagged with its cycle number
    always @(negedge clk) begin
        if (bus.msg_start) obs_q.push_back(ev_t'{K_START, cyc, int'(bus.msg_type)});
        if (bus.msg_end) obs_q.push_back(ev_t'{K_END, cyc, 0});
        if (bus.unknown_type) obs_q.push_back(ev_t'{K_UNK, cyc, 0});
        if (bus.trunc_error) obs_q.push_back(ev_t'{K_TRUNC, cyc, 0});
        if (bus.dec_mismatch) obs_q.push_back(ev_t'{K_MISM, cyc, 0});
        if (bus.dec_enable) obs_q.push_back(ev_t'{K_LVL, cyc, int'(bus.byte_index)});
        cyc++;
    end

    task automatic step(input logic [7:0] b, input logic v, input logic d);
        @(posedge clk);
        #1;
        bus.byte_in = b;
        bus.valid_in = v;
        bus.dec_valid_any = d | pend_dv;
        pend_dv = 1'b0;
        @(negedge clk);
        #1;
        now = cyc - 1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(8'h00, 1'b0, 1'b0);
    endtask

    // streams one complete message; good=1 pulses dec_valid_any in the msg_end cycle
    task automatic send_msg(input logic [7:0] t, input int len, input bit good);
        for (int i = 0; i < len; i++) begin
            step(i == 0 ? t : 8'($urandom), 1'b1, 1'b0);
            if (i == 0) exp_q.push_back(ev_t'{K_START, now, int'(t)});
            exp_q.push_back(ev_t'{K_LVL, now, i});
        end
        exp_q.push_back(ev_t'{K_END, now + 1, 0});
        if (!good) begin
            exp_q.push_back(ev_t'{K_MISM, now + 2, 0});
            exp_errs++;
        end
        exp_msgs++;
        pend_dv = good;
    endtask

    function automatic bit take(ev_t e);
        foreach (obs_q[i]) begin
            if (obs_q[i].kind == e.kind && obs_q[i].cyc == e.cyc && obs_q[i].val == e.val) begin
                obs_q.delete(i);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic test_reset();
        bus.byte_in = 8'h44;
        bus.valid_in = 1'b1;
        bus.dec_valid_any = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.dec_enable !== 1'b0) begin errors++; $display("FAIL reset_dec_enable got=%b exp=0", bus.dec_enable); end
        checks++; if (bus.msg_start !== 1'b0) begin errors++; $display("FAIL reset_msg_start got=%b exp=0", bus.msg_start); end
        checks++; if (bus.msg_type !== 8'h00) begin errors++; $display("FAIL reset_msg_type got=%h exp=00", bus.msg_type); end
        checks++; if (bus.byte_index !== 6'd0) begin errors++; $display("FAIL reset_byte_index got=%0d exp=0", bus.byte_index); end
        checks++; if (bus.msg_end !== 1'b0) begin errors++; $display("FAIL reset_msg_end got=%b exp=0", bus.msg_end); end
        checks++; if (bus.unknown_type !== 1'b0) begin errors++; $display("FAIL reset_unknown got=%b exp=0", bus.unknown_type); end
        checks++; if (bus.trunc_error !== 1'b0) begin errors++; $display("FAIL reset_trunc got=%b exp=0", bus.trunc_error); end
        checks++; if (bus.dec_mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch got=%b exp=0", bus.dec_mismatch); end
        checks++; if (bus.msg_count !== 16'd0) begin errors++; $display("FAIL reset_msg_count got=%0d exp=0", bus.msg_count); end
        checks++; if (bus.err_count !== 16'd0) begin errors++; $display("FAIL reset_err_count got=%0d exp=0", bus.err_count); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.valid_in = 1'b0;
        bus.dec_valid_any = 1'b0;
        obs_q.delete();
    endtask

    task automatic test_single();
        ev_t e;
        obs_q.delete();
        send_msg(8'h44, 9, 1'b1);
        idle(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (!take(e)) begin errors++; $display("FAIL single_event kind=%0d cyc=%0d val=%0h observed=none required=present", e.kind, e.cyc, e.val); end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL single_extra observed=%0d first kind=%0d cyc=%0d val=%0h required=0", obs_q.size(), obs_q[0].kind, obs_q[0].cyc, obs_q[0].val); end
        checks++;
        if (bus.msg_count !== (STATS ? 16'(exp_msgs) : 16'd0)) begin errors++; $display("FAIL single_msg_count got=%0d exp=%0d", bus.msg_count, STATS ? exp_msgs : 0); end
    endtask

    task automatic test_back_to_back();
        ev_t e;
        obs_q.delete();
        send_msg(8'h44, 9, 1'b1);
        send_msg(8'h41, 36, 1'b1);
        idle(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (!take(e)) begin errors++; $display("FAIL b2b_event kind=%0d cyc=%0d val=%0h observed=none required=present", e.kind, e.cyc, e.val); end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL b2b_extra observed=%0d first kind=%0d cyc=%0d val=%0h required=0", obs_q.size(), obs_q[0].kind, obs_q[0].cyc, obs_q[0].val); end
        checks++;
        if (bus.msg_type !== 8'h41) begin errors++; $display("FAIL b2b_msg_type got=%h exp=41", bus.msg_type); end
        checks++;
        if (bus.msg_count !== (STATS ? 16'(exp_msgs) : 16'd0)) begin errors++; $display("FAIL b2b_msg_count got=%0d exp=%0d", bus.msg_count, STATS ? exp_msgs : 0); end
    endtask

    task automatic test_unknown();
        ev_t e;
        obs_q.delete();
        step(8'h5A, 1'b1, 1'b0);
        exp_q.push_back(ev_t'{K_UNK, now, 0});
        exp_errs++;
        checks++;
        if (bus.dec_enable !== 1'b0) begin errors++; $display("FAIL unknown_dec_enable got=%b exp=0", bus.dec_enable); end
        for (int i = 0; i < 4; i++) begin
            step(i == 0 ? 8'h44 : 8'($urandom), 1'b1, 1'b0);
            checks++;
            if (bus.dec_enable !== 1'b0) begin errors++; $display("FAIL discard_dec_enable byte=%0d got=%b exp=0", i + 1, bus.dec_enable); end
        end
        idle(1);
        send_msg(8'h44, 9, 1'b1);
        idle(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (!take(e)) begin errors++; $display("FAIL unknown_event kind=%0d cyc=%0d val=%0h observed=none required=present", e.kind, e.cyc, e.val); end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL unknown_extra observed=%0d first kind=%0d cyc=%0d val=%0h required=0", obs_q.size(), obs_q[0].kind, obs_q[0].cyc, obs_q[0].val); end
        checks++;
        if (bus.err_count !== (STATS ? 16'(exp_errs) : 16'd0)) begin errors++; $display("FAIL unknown_err_count got=%0d exp=%0d", bus.err_count, STATS ? exp_errs : 0); end
    endtask

    task automatic test_trunc();
        ev_t e;
        obs_q.delete();
        for (int i = 0; i <= 10; i++) begin
            step(i == 0 ? 8'h58 : 8'($urandom), 1'b1, 1'b0);
            if (i == 0) exp_q.push_back(ev_t'{K_START, now, 32'h58});
            exp_q.push_back(ev_t'{K_LVL, now, i});
        end
        idle(1);
        exp_q.push_back(ev_t'{K_TRUNC, now + 1, 0});
        exp_errs++;
        checks++;
        if (bus.dec_enable !== 1'b0) begin errors++; $display("FAIL trunc_dec_enable got=%b exp=0", bus.dec_enable); end
        idle(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (!take(e)) begin errors++; $display("FAIL trunc_event kind=%0d cyc=%0d val=%0h observed=none required=present", e.kind, e.cyc, e.val); end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL trunc_extra observed=%0d first kind=%0d cyc=%0d val=%0h required=0", obs_q.size(), obs_q[0].kind, obs_q[0].cyc, obs_q[0].val); end
        checks++;
        if (bus.err_count !== (STATS ? 16'(exp_errs) : 16'd0)) begin errors++; $display("FAIL trunc_err_count got=%0d exp=%0d", bus.err_count, STATS ? exp_errs : 0); end
    endtask

    task automatic test_mismatch();
        ev_t e;
        obs_q.delete();
        send_msg(8'h45, 31, 1'b0);
        idle(2);
        step(8'h00, 1'b0, 1'b1);
        exp_q.push_back(ev_t'{K_MISM, now + 1, 0});
        exp_errs++;
        idle(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (!take(e)) begin errors++; $display("FAIL mismatch_event kind=%0d cyc=%0d val=%0h observed=none required=present", e.kind, e.cyc, e.val); end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL mismatch_extra observed=%0d first kind=%0d cyc=%0d val=%0h required=0", obs_q.size(), obs_q[0].kind, obs_q[0].cyc, obs_q[0].val); end
        checks++;
        if (bus.err_count !== (STATS ? 16'(exp_errs) : 16'd0)) begin errors++; $display("FAIL mismatch_err_count got=%0d exp=%0d", bus.err_count, STATS ? exp_errs : 0); end
    endtask

    task automatic test_reset_mid();
        ev_t e;
        obs_q.delete();
        for (int i = 0; i <= 20; i++) begin
            step(i == 0 ? 8'h50 : 8'($urandom), 1'b1, 1'b0);
            if (i == 0) exp_q.push_back(ev_t'{K_START, now, 32'h50});
            exp_q.push_back(ev_t'{K_LVL, now, i});
        end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.dec_enable !== 1'b0) begin errors++; $display("FAIL rstmid_dec_enable got=%b exp=0", bus.dec_enable); end
        checks++; if (bus.byte_index !== 6'd0) begin errors++; $display("FAIL rstmid_byte_index got=%0d exp=0", bus.byte_index); end
        checks++; if (bus.msg_type !== 8'h00) begin errors++; $display("FAIL rstmid_msg_type got=%h exp=00", bus.msg_type); end
        checks++; if (bus.msg_count !== 16'd0) begin errors++; $display("FAIL rstmid_msg_count got=%0d exp=0", bus.msg_count); end
        checks++; if (bus.err_count !== 16'd0) begin errors++; $display("FAIL rstmid_err_count got=%0d exp=0", bus.err_count); end
        step(8'($urandom), 1'b1, 1'b0);
        step(8'($urandom), 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.valid_in = 1'b0;
        exp_msgs = 0;
        exp_errs = 0;
        send_msg(8'h44, 9, 1'b1);
        idle(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (!take(e)) begin errors++; $display("FAIL rstmid_event kind=%0d cyc=%0d val=%0h observed=none required=present", e.kind, e.cyc, e.val); end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL rstmid_extra observed=%0d first kind=%0d cyc=%0d val=%0h required=0", obs_q.size(), obs_q[0].kind, obs_q[0].cyc, obs_q[0].val); end
        checks++;
        if (bus.msg_count !== (STATS ? 16'd1 : 16'd0)) begin errors++; $display("FAIL rstmid_msg_count got=%0d exp=%0d", bus.msg_count, STATS ? 1 : 0); end
        checks++;
        if (bus.err_count !== 16'd0) begin errors++; $display("FAIL rstmid_err_count got=%0d exp=0", bus.err_count); end
    endtask

`ifdef ITCH_SEQ_STATS_EN
    task automatic test_saturation();
        ev_t e;
        obs_q.delete();
        force dut.err_cnt = 16'hFFFF;
        idle(1);
        release dut.err_cnt;
        step(8'h00, 1'b1, 1'b0);
        exp_q.push_back(ev_t'{K_UNK, now, 0});
        idle(3);
        checks++;
        if (bus.err_count !== 16'hFFFF) begin errors++; $display("FAIL sat_err_count got=%h exp=ffff", bus.err_count); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (!take(e)) begin errors++; $display("FAIL sat_event kind=%0d cyc=%0d val=%0h observed=none required=present", e.kind, e.cyc, e.val); end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL sat_extra observed=%0d first kind=%0d cyc=%0d val=%0h required=0", obs_q.size(), obs_q[0].kind, obs_q[0].cyc, obs_q[0].val); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_unknown();
        test_trunc();
        test_mismatch();
        test_reset_mid();
`ifdef ITCH_SEQ_STATS_EN
        test_saturation();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
